ft245_device_emulator: RTL and testbench
========================================

FT245_DEVICE_EMULATOR -- requirements
Module: ft245_device_emulator

Interface
REQ-001 Parameter DEPTH, default 16: entries in each FIFO; SHALL be a power of two, at least 2.
REQ-002 Parameter RECOVERY, default 2: clk cycles the flag stays deasserted after each bus strobe; SHALL be at least 1.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 host_wr_data  in  8  byte pushed into the RX FIFO (host -> FPGA direction).
REQ-006 host_wr_en  in  1  push strobe for the RX FIFO.
REQ-007 host_rx_full  out  1  RX FIFO full.
REQ-008 host_rd_data  out  8  head of the TX FIFO (FPGA -> host direction).
REQ-009 host_rd_en  in  1  pop strobe for the TX FIFO.
REQ-010 host_tx_empty  out  1  TX FIFO empty.
REQ-011 ft_rxf_n  out  1  active-low "data available to read" flag.
REQ-012 ft_txe_n  out  1  active-low "space available to write" flag.
REQ-013 ft_rd_n  in  1  active-low read strobe from the FPGA, synchronous to clk.
REQ-014 ft_wr_n  in  1  active-low write strobe from the FPGA, synchronous to clk.
REQ-015 ft_d_in  in  8  bus value driven by the FPGA.
REQ-016 ft_d_out  out  8  bus value driven by the emulator.
REQ-017 ft_d_oe  out  1  emulator bus-drive enable.
REQ-018 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-019 ft_rd_n and ft_wr_n SHALL each be registered once; a falling edge is current 0 with previous 1, and a rising edge is current 1 with previous 0.
REQ-020 RX FIFO: push on host_wr_en && !host_rx_full; a push while full SHALL be dropped without error.
REQ-021 TX FIFO: pop on host_rd_en && !host_tx_empty; host_rd_data SHALL show the head combinationally; a pop while empty SHALL be ignored.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy counters SHALL be log2(DEPTH)+1 bits wide.
REQ-023 Read FSM states: RD_IDLE, RD_ACTIVE, RD_RECOVER.
REQ-024 ft_rxf_n SHALL be 0 exactly when the read FSM is in RD_IDLE and the RX FIFO is not empty.
REQ-025 RD_IDLE -> RD_ACTIVE on an ft_rd_n falling edge with ft_rxf_n=0; from the next cycle, ft_d_oe=1 and ft_d_out=RX head, held stable while ft_rd_n=0.
REQ-026 RD_ACTIVE -> RD_RECOVER on an ft_rd_n rising edge: pop the RX head that cycle, ft_d_oe=0 from the next cycle, ft_rxf_n=1 for RECOVERY cycles, then RD_IDLE.
REQ-027 Write FSM states: WR_IDLE, WR_ACTIVE, WR_RECOVER.
REQ-028 ft_txe_n SHALL be 0 exactly when the write FSM is in WR_IDLE and the TX FIFO is not full.
REQ-029 WR_IDLE -> WR_ACTIVE on an ft_wr_n falling edge with ft_txe_n=0, pushing the registered ft_d_in sampled with that edge into the TX FIFO.
REQ-030 WR_ACTIVE -> WR_RECOVER on an ft_wr_n rising edge; ft_txe_n=1 for RECOVERY further cycles, then WR_IDLE.
REQ-031 proto_err SHALL set on any of: an ft_rd_n falling edge while ft_rxf_n=1; an ft_wr_n falling edge while ft_txe_n=1; ft_rd_n=0 and ft_wr_n=0 in the same cycle.
REQ-032 A flagged strobe SHALL cause no push, no pop and no state change; a rejected read SHALL keep ft_d_oe=0.
REQ-033 A host push and a bus pop on the RX FIFO in the same cycle SHALL both take effect with occupancy unchanged; the same SHALL hold for a bus push and a host pop on the TX FIFO.
REQ-034 Pushing into an empty RX FIFO SHALL make ft_rxf_n=0 on the cycle after the push.

Reset
REQ-035 While rst=1: FIFOs empty; both FSMs idle; ft_rxf_n=1, ft_txe_n=1, ft_d_oe=0, ft_d_out=0x00, proto_err=0, host_rx_full=0, host_tx_empty=1.
REQ-036 On the first cycle after rst falls, ft_txe_n SHALL be 0.
REQ-037 rst asserted mid-strobe SHALL abort the transfer with no partial push or pop; the edge-detect registers SHALL reset to 1.

Verification
REQ-038 Push 0xA5, 0x3C from host; two FPGA read strobes of 3 cycles each, RECOVERY=2 -> bus shows 0xA5 then 0x3C; ft_rxf_n high 2 cycles after each strobe; ft_rxf_n=1 at end.
REQ-039 Write strobe with ft_d_in=0x5A -> host_tx_empty=0, host_rd_data=0x5A; ft_txe_n high through the strobe plus 2 cycles.
REQ-040 DEPTH writes without host pops -> ft_txe_n stays 1 after the last strobe; one host pop -> ft_txe_n=0 once recovery ends.
REQ-041 ft_rd_n falling edge with the RX FIFO empty -> proto_err=1, ft_d_oe stays 0; error persists until rst.
REQ-042 ft_rd_n and ft_wr_n low together -> proto_err=1, neither FIFO's occupancy changes.
REQ-043 rst pulsed while ft_d_oe=1 -> next cycle ft_d_oe=0 and ft_rxf_n=1; after release, ft_txe_n=0 and host_tx_empty=1.

Source files
------------

// File: rtl/ft245_device_emulator_if.sv
// Signal bundle between the FT245 emulator, the host-side FIFO ports and the
// FPGA-side parallel bus. The emulator connects as slave, the driver as master.
interface ft245_device_emulator_if;
  logic [7:0] host_wr_data;
  logic       host_wr_en;
  logic       host_rx_full;
  logic [7:0] host_rd_data;
  logic       host_rd_en;
  logic       host_tx_empty;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic       ft_rd_n;
  logic       ft_wr_n;
  logic [7:0] ft_d_in;
  logic [7:0] ft_d_out;
  logic       ft_d_oe;
  logic       proto_err;

  modport slave (
    input  host_wr_data, host_wr_en, host_rd_en, ft_rd_n, ft_wr_n, ft_d_in,
    output host_rx_full, host_rd_data, host_tx_empty,
           ft_rxf_n, ft_txe_n, ft_d_out, ft_d_oe, proto_err
  );

  modport master (
    output host_wr_data, host_wr_en, host_rd_en, ft_rd_n, ft_wr_n, ft_d_in,
    input  host_rx_full, host_rd_data, host_tx_empty,
           ft_rxf_n, ft_txe_n, ft_d_out, ft_d_oe, proto_err
  );
endinterface

// File: rtl/ft245_device_emulator.sv
// FT245-style device emulator: host RX/TX FIFOs bridged to a strobe-driven bus.
// state      | meaning
// RD_IDLE    | waiting for a read strobe; rxf_n low when RX has data
// RD_ACTIVE  | driving the RX head onto the bus while ft_rd_n is low
// RD_RECOVER | RX head popped; rxf_n held high for RECOVERY cycles
// WR_IDLE    | waiting for a write strobe; txe_n low when TX has room
// WR_ACTIVE  | byte pushed into TX; waiting for ft_wr_n to rise
// WR_RECOVER | txe_n held high for RECOVERY cycles
module ft245_device_emulator #(
  parameter int DEPTH    = 16,
  parameter int RECOVERY = 2
) (
  input logic clk,
  input logic rst,
  ft245_device_emulator_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RECOVERY + 1);

  typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_RECOVER} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_RECOVER} wr_state_t;

  rd_state_t     rd_state;
  wr_state_t     wr_state;
  logic [RW-1:0] rd_rec_cnt, wr_rec_cnt;

  logic          rd_s, rd_p, wr_s, wr_p;
  logic [7:0]    d_s;
  logic [7:0]    d_out;
  logic          d_oe, proto_err;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rxf_n, txe_n;
  logic rd_fall, rd_rise, wr_fall, wr_rise, both_low;
  logic rd_start, wr_start, err_hit;
  logic rx_push, rx_pop, tx_push, tx_pop;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(DEPTH));

  // Flags are forced inactive while rst is held, before the state registers clear.
  assign rxf_n = !(!rst && rd_state == RD_IDLE && !rx_empty);
  assign txe_n = !(!rst && wr_state == WR_IDLE && !tx_full);

  assign rd_fall  = !rd_s && rd_p;
  assign rd_rise  = rd_s && !rd_p;
  assign wr_fall  = !wr_s && wr_p;
  assign wr_rise  = wr_s && !wr_p;
  assign both_low = !rd_s && !wr_s;

  assign rd_start = rd_fall && !rxf_n && !both_low;
  assign wr_start = wr_fall && !txe_n && !both_low;
  assign err_hit  = (rd_fall && rxf_n) || (wr_fall && txe_n) || both_low;

  assign rx_push = bus.host_wr_en && !rx_full;
  assign rx_pop  = (rd_state == RD_ACTIVE) && rd_rise;
  assign tx_push = wr_start;
  assign tx_pop  = bus.host_rd_en && !tx_empty;

  assign bus.ft_rxf_n      = rxf_n;
  assign bus.ft_txe_n      = txe_n;
  assign bus.ft_d_out      = d_out;
  assign bus.ft_d_oe       = d_oe;
  assign bus.proto_err     = proto_err;
  assign bus.host_rx_full  = rx_full && !rst;
  assign bus.host_tx_empty = tx_empty || rst;
  assign bus.host_rd_data  = tx_mem[tx_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s <= 1'b1;
      rd_p <= 1'b1;
      wr_s <= 1'b1;
      wr_p <= 1'b1;
      d_s  <= '0;
    end else begin
      rd_s <= bus.ft_rd_n;
      rd_p <= rd_s;
      wr_s <= bus.ft_wr_n;
      wr_p <= wr_s;
      d_s  <= bus.ft_d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem[rx_wp] <= bus.host_wr_data;
    if (!rst && tx_push) tx_mem[tx_wp] <= d_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      wr_state   <= WR_IDLE;
      rd_rec_cnt <= '0;
      wr_rec_cnt <= '0;
      d_out      <= '0;
      d_oe       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (err_hit) proto_err <= 1'b1;

      case (rd_state)
        RD_IDLE: if (rd_start) begin
          rd_state <= RD_ACTIVE;
          d_oe     <= 1'b1;
          d_out    <= rx_mem[rx_rp];
        end
        RD_ACTIVE: if (rd_rise) begin
          rd_state   <= RD_RECOVER;
          d_oe       <= 1'b0;
          rd_rec_cnt <= RW'(RECOVERY - 1);
        end
        RD_RECOVER: begin
          if (rd_rec_cnt == '0) rd_state <= RD_IDLE;
          else                  rd_rec_cnt <= rd_rec_cnt - RW'(1);
        end
        default: rd_state <= RD_IDLE;
      endcase

      case (wr_state)
        WR_IDLE: if (wr_start) wr_state <= WR_ACTIVE;
        WR_ACTIVE: if (wr_rise) begin
          wr_state   <= WR_RECOVER;
          wr_rec_cnt <= RW'(RECOVERY - 1);
        end
        WR_RECOVER: begin
          if (wr_rec_cnt == '0) wr_state <= WR_IDLE;
          else                  wr_rec_cnt <= wr_rec_cnt - RW'(1);
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft245_device_emulator.sv
// Directed and randomized bench for ft245_device_emulator against a queue-based
// reference of both FIFOs and the bus flag/recovery timing.
module tb_ft245_device_emulator;
  localparam int DEPTH    = 8;
  localparam int RECOVERY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ft245_device_emulator_if bus();

  ft245_device_emulator #(.DEPTH(DEPTH), .RECOVERY(RECOVERY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] b);
    bus.host_wr_data = b;
    bus.host_wr_en   = 1'b1;
    tick();
    bus.host_wr_en   = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  task automatic host_pop();
    logic [7:0] dummy;
    if (tx_q.size() > 0) begin
      chk("host_rd_data", bus.host_rd_data, tx_q[0]);
      dummy = tx_q.pop_front();
    end
    bus.host_rd_en = 1'b1;
    tick();
    bus.host_rd_en = 1'b0;
  endtask

  task automatic wait_low(input bit is_rd, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((is_rd ? bus.ft_rxf_n : bus.ft_txe_n) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk(is_rd ? "rxf_wait" : "txe_wait", is_rd ? bus.ft_rxf_n : bus.ft_txe_n, 0);
  endtask

  // Three-cycle read strobe; recovery is the run of oe=0 with rxf_n still high.
  task automatic bus_read();
    bit ok;
    logic [7:0] exp;
    int cnt;
    wait_low(1'b1, ok);
    if (!ok) return;
    exp = rx_q.pop_front();
    bus.ft_rd_n = 1'b0;
    tick();
    tick();
    chk("rd_oe", bus.ft_d_oe, 1);
    chk("rd_data", bus.ft_d_out, exp);
    tick();
    chk("rd_data_hold", bus.ft_d_out, exp);
    bus.ft_rd_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < RECOVERY + 4; k++) begin
      tick();
      if (bus.ft_rxf_n == 1'b0) break;
      if (bus.ft_d_oe == 1'b0) cnt++;
    end
    if (rx_q.size() != 0) chk("rd_recovery", cnt, RECOVERY);
    else chk("rxf_after_drain", bus.ft_rxf_n, 1);
    chk("rd_oe_off", bus.ft_d_oe, 0);
  endtask

  // Three-cycle write strobe; data bus is scrambled after the sampling edge.
  task automatic bus_write(input logic [7:0] b);
    bit ok;
    int cnt;
    bit was_empty;
    wait_low(1'b0, ok);
    if (!ok) return;
    was_empty = (tx_q.size() == 0);
    bus.ft_d_in = b;
    bus.ft_wr_n = 1'b0;
    tick();
    bus.ft_d_in = ~b;
    tick();
    chk("wr_tx_empty", bus.host_tx_empty, 0);
    if (was_empty) chk("wr_head", bus.host_rd_data, b);
    chk("wr_txe_during", bus.ft_txe_n, 1);
    tick();
    bus.ft_wr_n = 1'b1;
    tx_q.push_back(b);
    cnt = 0;
    for (int k = 0; k < RECOVERY + 4; k++) begin
      tick();
      if (bus.ft_txe_n == 1'b0) break;
      cnt++;
    end
    // One cycle of edge registration precedes the recovery window.
    if (tx_q.size() < DEPTH) chk("wr_recovery", cnt, RECOVERY + 1);
    else chk("txe_full", bus.ft_txe_n, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] dummy;
    rst = 1'b1;
    bus.host_wr_data = '0;
    bus.host_wr_en   = 1'b0;
    bus.host_rd_en   = 1'b0;
    bus.ft_rd_n      = 1'b1;
    bus.ft_wr_n      = 1'b1;
    bus.ft_d_in      = '0;
    tick();
    tick();
    tick();
    chk("rst_rxf_n", bus.ft_rxf_n, 1);
    chk("rst_txe_n", bus.ft_txe_n, 1);
    chk("rst_oe", bus.ft_d_oe, 0);
    chk("rst_dout", bus.ft_d_out, 8'h00);
    chk("rst_err", bus.proto_err, 0);
    chk("rst_rx_full", bus.host_rx_full, 0);
    chk("rst_tx_empty", bus.host_tx_empty, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_txe_n", bus.ft_txe_n, 0);
    chk("post_rst_rxf_n", bus.ft_rxf_n, 1);

    // Two host bytes read back over the bus.
    host_push(8'hA5);
    chk("rxf_after_push", bus.ft_rxf_n, 0);
    host_push(8'h3C);
    bus_read();
    bus_read();
    chk("rxf_end", bus.ft_rxf_n, 1);

    // Single bus write seen by the host.
    bus_write(8'h5A);
    host_pop();
    chk("tx_empty_after_pop", bus.host_tx_empty, 1);

    // Fill TX from the bus; txe_n must stay high until the host makes room.
    for (int i = 0; i < DEPTH; i++) bus_write(8'($urandom));
    tick();
    tick();
    chk("txe_full_hold", bus.ft_txe_n, 1);
    host_pop();
    chk("txe_after_room", bus.ft_txe_n, 0);
    while (tx_q.size() > 0) host_pop();
    chk("tx_drained", bus.host_tx_empty, 1);
    host_pop();
    chk("tx_empty_pop_ignored", bus.host_tx_empty, 1);

    // Overfill RX: the extra byte is dropped, order kept.
    for (int i = 0; i < DEPTH + 1; i++) host_push(8'($urandom));
    chk("rx_full", bus.host_rx_full, 1);
    while (rx_q.size() > 0) bus_read();
    chk("rx_drained_rxf", bus.ft_rxf_n, 1);

    // Bus push and host pop on TX in the same cycle.
    bus_write(8'h11);
    bus.ft_d_in = 8'h22;
    bus.ft_wr_n = 1'b0;
    tick();
    bus.ft_d_in    = 8'hEE;
    chk("simul_tx_head", bus.host_rd_data, 8'h11);
    bus.host_rd_en = 1'b1;
    tick();
    bus.host_rd_en = 1'b0;
    dummy = tx_q.pop_front();
    tx_q.push_back(8'h22);
    chk("simul_tx_not_empty", bus.host_tx_empty, 0);
    chk("simul_tx_new_head", bus.host_rd_data, 8'h22);
    bus.ft_wr_n = 1'b1;
    repeat (RECOVERY + 4) tick();
    host_pop();
    chk("simul_tx_empty", bus.host_tx_empty, 1);

    // Host push and bus pop on RX in the same cycle.
    host_push(8'h81);
    host_push(8'h82);
    bus.ft_rd_n = 1'b0;
    tick();
    tick();
    chk("simul_rx_data", bus.ft_d_out, 8'h81);
    tick();
    bus.ft_rd_n = 1'b1;
    tick();
    bus.host_wr_data = 8'h83;
    bus.host_wr_en   = 1'b1;
    tick();
    bus.host_wr_en   = 1'b0;
    dummy = rx_q.pop_front();
    rx_q.push_back(8'h83);
    repeat (RECOVERY + 4) tick();
    bus_read();
    bus_read();
    chk("simul_rx_end", bus.ft_rxf_n, 1);

    // Randomized mix against the queue model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: host_push(8'($urandom));
        1: if (rx_q.size() > 0) bus_read();
        2: if (tx_q.size() < DEPTH) bus_write(8'($urandom));
        default: host_pop();
      endcase
      chk("rnd_rx_full", bus.host_rx_full, rx_q.size() == DEPTH);
      chk("rnd_tx_empty", bus.host_tx_empty, tx_q.size() == 0);
      chk("rnd_rxf_n", bus.ft_rxf_n, rx_q.size() == 0);
      chk("rnd_txe_n", bus.ft_txe_n, tx_q.size() == DEPTH);
      chk("rnd_err", bus.proto_err, 0);
    end

    // Read strobe with nothing to read.
    do_reset();
    bus.ft_rd_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bad_rd_oe", bus.ft_d_oe, 0);
    end
    bus.ft_rd_n = 1'b1;
    repeat (4) tick();
    chk("bad_rd_err", bus.proto_err, 1);
    bus_write(8'h44);
    chk("err_sticky", bus.proto_err, 1);

    // Both strobes low together.
    do_reset();
    chk("err_cleared", bus.proto_err, 0);
    host_push(8'h77);
    bus.ft_d_in = 8'h99;
    bus.ft_rd_n = 1'b0;
    bus.ft_wr_n = 1'b0;
    repeat (3) tick();
    bus.ft_rd_n = 1'b1;
    bus.ft_wr_n = 1'b1;
    repeat (RECOVERY + 4) tick();
    chk("both_err", bus.proto_err, 1);
    chk("both_tx_empty", bus.host_tx_empty, 1);
    chk("both_rxf_n", bus.ft_rxf_n, 0);
    chk("both_oe", bus.ft_d_oe, 0);
    bus_read();

    // Reset in the middle of a read strobe.
    do_reset();
    host_push(8'hC1);
    host_push(8'hC2);
    bus.ft_rd_n = 1'b0;
    tick();
    tick();
    chk("mid_oe", bus.ft_d_oe, 1);
    rst = 1'b1;
    bus.ft_rd_n = 1'b1;
    tick();
    chk("mid_rst_oe", bus.ft_d_oe, 0);
    chk("mid_rst_rxf_n", bus.ft_rxf_n, 1);
    chk("mid_rst_dout", bus.ft_d_out, 8'h00);
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    tick();
    chk("mid_rel_txe_n", bus.ft_txe_n, 0);
    chk("mid_rel_tx_empty", bus.host_tx_empty, 1);
    chk("mid_rel_rxf_n", bus.ft_rxf_n, 1);
    chk("mid_rel_err", bus.proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
